// File: rtl/bp_fe_cmd_sequencer.sv
// Frontend command sequencer: buffers backend commands and paces their issue to pc_gen,
// stalling for fences and redirects. Optional macro: BP_FE_CMD_SEQ_ATTABOY_DROP_EN.
module bp_fe_cmd_sequencer #(
   parameter int cmd_width_p = 128,
   parameter int els_p       = 2,
   parameter int holdoff_p   = 3
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic [cmd_width_p-1:0] be_cmd_i,
   input  logic [2:0]             be_cmd_opcode_i,
   input  logic                   be_cmd_v_i,
   output logic                   be_cmd_ready_o,
   output logic [cmd_width_p-1:0] fe_cmd_o,
   output logic                   fe_cmd_v_o,
   input  logic                   fe_cmd_yumi_i,
   input  logic                   fence_done_i,
   output logic                   busy_o
);

   localparam int ptr_w_lp = $clog2(els_p);
   localparam int cnt_w_lp = $clog2(els_p + 1);
   localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(els_p - 1);
   localparam logic [cnt_w_lp-1:0] full_cnt_lp = cnt_w_lp'(els_p);
   localparam logic [3:0]          holdoff_lp  = 4'(holdoff_p);

   localparam logic [2:0] op_state_reset  = 3'd0;
   localparam logic [2:0] op_pc_redirect  = 3'd1;
   localparam logic [2:0] op_icache_fence = 3'd3;
   localparam logic [2:0] op_itlb_fence   = 3'd4;
   localparam logic [2:0] op_attaboy      = 3'd5;

   typedef enum logic [1:0] {e_run, e_fence, e_holdoff} state_e;

   typedef struct packed {
      logic [2:0]             opcode;
      logic [cmd_width_p-1:0] payload;
   } entry_s;

   entry_s                mem_q [els_p];
   state_e                state_q, state_d;
   logic [ptr_w_lp-1:0]   rptr_q, rptr_d;
   logic [ptr_w_lp-1:0]   wptr_q, wptr_d;
   logic [cnt_w_lp-1:0]   count_q, count_d;
   logic [3:0]            hold_cnt_q, hold_cnt_d;

   logic   empty, full, drop, enq, deq;
   entry_s head;

   assign empty = (count_q == '0);
   assign full  = (count_q == full_cnt_lp);
   assign head  = mem_q[rptr_q];

`ifdef BP_FE_CMD_SEQ_ATTABOY_DROP_EN
   // A full buffer still swallows attaboys; they carry no state pc_gen needs.
   assign drop           = be_cmd_v_i & full & (be_cmd_opcode_i == op_attaboy);
   assign be_cmd_ready_o = ~reset_i & (~full | (be_cmd_opcode_i == op_attaboy));
`else
   assign drop           = 1'b0;
   assign be_cmd_ready_o = ~reset_i & ~full;
`endif

   assign fe_cmd_v_o = ~reset_i & (state_q == e_run) & ~empty;
   assign fe_cmd_o   = head.payload;
   assign busy_o     = ~reset_i & (~empty | (state_q != e_run));

   assign enq = be_cmd_v_i & be_cmd_ready_o & ~drop;
   assign deq = fe_cmd_yumi_i & fe_cmd_v_o;

   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      state_d    = state_q;
      rptr_d     = rptr_q;
      wptr_d     = wptr_q;
      count_d    = count_q;
      hold_cnt_d = hold_cnt_q;

      if (enq) wptr_d = (wptr_q == last_ptr_lp) ? '0 : wptr_q + 1'b1;
      if (deq) rptr_d = (rptr_q == last_ptr_lp) ? '0 : rptr_q + 1'b1;

      if (enq && !deq)      count_d = count_q + 1'b1;
      else if (deq && !enq) count_d = count_q - 1'b1;

      unique case (state_q)
         e_run: begin
            if (deq) begin
               if (head.opcode == op_icache_fence || head.opcode == op_itlb_fence) begin
                  state_d = e_fence;
               end else if ((head.opcode == op_state_reset || head.opcode == op_pc_redirect)
                            && holdoff_lp != 4'd0) begin
                  state_d    = e_holdoff;
                  hold_cnt_d = holdoff_lp;
               end
            end
         end
         e_fence: begin
            if (fence_done_i) begin
               if (holdoff_lp != 4'd0) begin
                  state_d    = e_holdoff;
                  hold_cnt_d = holdoff_lp;
               end else begin
                  state_d = e_run;
               end
            end
         end
         e_holdoff: begin
            hold_cnt_d = hold_cnt_q - 1'b1;
            if (hold_cnt_q == 4'd1) state_d = e_run;
         end
         default: state_d = e_run;
      endcase
   end

   // NOTE: buffer storage is deliberately not reset; an entry is only read once count covers it.
   always_ff @(posedge clk_i) begin
      if (enq) mem_q[wptr_q] <= '{opcode: be_cmd_opcode_i, payload: be_cmd_i};
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= e_run;
         rptr_q     <= '0;
         wptr_q     <= '0;
         count_q    <= '0;
         hold_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         rptr_q     <= rptr_d;
         wptr_q     <= wptr_d;
         count_q    <= count_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

endmodule

// File: doc/bp_fe_cmd_sequencer.md
BP_FE_CMD_SEQUENCER -- requirements
Module: bp_fe_cmd_sequencer

Interface
REQ-001 SHALL have parameter cmd_width_p, default 128, meaning FE command payload width in bits.
REQ-002 SHALL have parameter els_p, default 2, meaning command buffer depth, legal range 2..8.
REQ-003 SHALL have parameter holdoff_p, default 3, meaning idle cycles inserted after any pc_redirection, state_reset or fence, legal range 0..15.
REQ-004 SHALL provide port clk_i, input, 1 bit, the single clock.
REQ-005 SHALL provide port reset_i, input, 1 bit, reset that is synchronous and active-high.
REQ-006 SHALL provide port be_cmd_i, input, cmd_width_p bits, command payload from the backend.
REQ-007 SHALL provide port be_cmd_opcode_i, input, 3 bits, command opcode: 0 state_reset, 1 pc_redirection, 2 itlb_fill, 3 icache_fence, 4 itlb_fence, 5 attaboy.
REQ-008 SHALL provide port be_cmd_v_i, input, 1 bit, backend command valid.
REQ-009 SHALL provide port be_cmd_ready_o, output, 1 bit, sequencer can accept a backend command.
REQ-010 SHALL provide port fe_cmd_o, output, cmd_width_p bits, head command payload presented to pc_gen.
REQ-011 SHALL provide port fe_cmd_v_o, output, 1 bit, head command valid.
REQ-012 SHALL provide port fe_cmd_yumi_i, input, 1 bit, pc_gen consumes the head command.
REQ-013 SHALL provide port fence_done_i, input, 1 bit, pulse from the I$/ITLB indicating the outstanding fence has completed.
REQ-014 SHALL provide port busy_o, output, 1 bit, buffer non-empty or state not e_run.

Function
REQ-015 SHALL buffer commands in an els_p-entry circular FIFO, with opcode stored alongside payload, and with read and write pointers wrapping from els_p-1 to 0.
REQ-016 SHALL enqueue when be_cmd_v_i & be_cmd_ready_o, where be_cmd_ready_o = ~full; a dequeue while full SHALL NOT permit a same-cycle enqueue.
REQ-017 SHALL implement an FSM with states e_run, e_fence and e_holdoff.
REQ-018 e_run: fe_cmd_v_o = ~empty, fe_cmd_o = head payload, with zero-cycle latency from the head becoming valid.
REQ-019 A yumi of opcode 3 or 4 SHALL cause e_run to transition to e_fence.
REQ-020 A yumi of opcode 0 or 1 SHALL load the holdoff counter with holdoff_p and cause e_run to transition to e_holdoff; when holdoff_p = 0 the FSM SHALL stay in e_run.
REQ-021 A yumi of opcode 2 or 5 SHALL leave the FSM in e_run, and back-to-back issue SHALL be allowed.
REQ-022 e_fence: fe_cmd_v_o = 0; when fence_done_i = 1 the FSM SHALL load the counter with holdoff_p and go to e_holdoff, or go to e_run if holdoff_p = 0.
REQ-023 e_holdoff: fe_cmd_v_o = 0; the counter SHALL decrement each cycle; the FSM SHALL go to e_run on the cycle the counter reaches 1.
REQ-024 fence_done_i SHALL be ignored outside e_fence, including a done arriving in the same cycle as the fence yumi.
REQ-025 fe_cmd_yumi_i asserted while fe_cmd_v_o = 0 SHALL be ignored, with no pointer or state change.
REQ-026 Simultaneous enqueue and dequeue when neither full nor empty SHALL preserve the occupancy count.
REQ-027 The FIFO SHALL preserve command order, and SHALL NOT bypass an empty FIFO: an enqueued command is visible on fe_cmd_o the cycle after it is accepted.

Reset
REQ-028 While reset_i = 1 the block SHALL drive be_cmd_ready_o = 0, fe_cmd_v_o = 0 and busy_o = 0.
REQ-029 On the first cycle after reset the block SHALL have state e_run, pointers 0, counter 0, FIFO empty and be_cmd_ready_o = 1.
REQ-030 A reset in e_fence or e_holdoff, or while the FIFO is non-empty, SHALL discard all buffered commands and the pending fence.

Configuration
REQ-031 The macro BP_FE_CMD_SEQ_ATTABOY_DROP_EN SHALL control attaboy dropping when the buffer is full.
REQ-032 With BP_FE_CMD_SEQ_ATTABOY_DROP_EN defined, be_cmd_ready_o SHALL be 1 when full and be_cmd_opcode_i = 5, and that attaboy SHALL be accepted and discarded without an enqueue.
REQ-033 Without BP_FE_CMD_SEQ_ATTABOY_DROP_EN, attaboys SHALL be backpressured like every other opcode.

Verification
REQ-034 The bench SHALL enqueue redirect (op 1), then attaboy (op 5), with holdoff_p=3 and yumi always 1 -> redirect issued at cycle t, attaboy fe_cmd_v_o high at t+4.
REQ-035 The bench SHALL enqueue icache_fence (op 3) with fence_done_i pulsed 10 cycles after yumi -> fe_cmd_v_o low for 10 + 3 cycles, then the next command is presented.
REQ-036 The bench SHALL, with els_p=2, enqueue 3 commands with yumi held 0 -> ready_o low after 2 enqueues; after one yumi, ready_o high the next cycle and order is preserved.
REQ-037 The bench SHALL run 20 enqueue/dequeue pairs with els_p=2 -> pointers wrap, payloads match the sent sequence 0..19.
REQ-038 The bench SHALL assert reset_i in e_fence with 2 entries buffered -> next cycle e_run, empty, busy_o=0, and a later fence_done_i is ignored.
REQ-039 The bench SHALL, with BP_FE_CMD_SEQ_ATTABOY_DROP_EN, present attaboy while full -> ready_o=1, accepted, never appears on fe_cmd_o; without the macro, ready_o=0.
